// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: FSM state encoding,
// opcode/funct constants, ALU operation classes and ALU control encodings.
// Optional feature macro: CTRL_BNE_EN (adds bne decoding).
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // True when DECODE knows where to send this opcode.
    function automatic logic is_supported_op(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef CTRL_BNE_EN
            OP_BNE: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// ALU decoder: maps the FSM's ALU operation class and the funct field onto
// the 3-bit ALU control. Unknown funct codes fall back to add.
import mips_ctrl_pkg::*;

module alu_decoder (
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Select the ALU operation from the operation class, consulting funct for R-type.
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_checker.sv
// Property checker for the controller: the memory write, register write and
// instruction register load never fire together.
module multicycle_ctrl_checker (
    input logic clk,
    input logic reset,
    input logic memwrite,
    input logic regwrite,
    input logic irwrite
);

    // At most one of the three write strobes may be high in any cycle.
    a_one_write: assert property (@(posedge clk) disable iff (reset)
        $onehot0({memwrite, regwrite, irwrite}));

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS core. Moore outputs are decoded
// from the registered state; pcen additionally folds in the ALU zero flag and
// illegal_op looks at the opcode while in DECODE.
// Optional feature macro: CTRL_BNE_EN (bne support through the BNEEX state).
import mips_ctrl_pkg::*;

module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal_op
);

    state_t state_r;
    state_t state_next_s;
    aluop_t aluop_s;
    logic   pcwrite_s;
    logic   branch_s;
`ifdef CTRL_BNE_EN
    logic   branchne_s;
`endif

    // State register; a synchronous reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic, driven by the current state and the opcode.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH: state_next_s = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next_s = S_MEMADR;
                    OP_RTYPE:     state_next_s = S_RTYPEEX;
                    OP_BEQ:       state_next_s = S_BEQEX;
                    OP_ADDI:      state_next_s = S_ADDIEX;
                    OP_J:         state_next_s = S_JEX;
`ifdef CTRL_BNE_EN
                    OP_BNE:       state_next_s = S_BNEEX;
`endif
                    default:      state_next_s = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                case (op)
                    OP_LW:   state_next_s = S_MEMRD;
                    OP_SW:   state_next_s = S_MEMWR;
                    default: state_next_s = S_FETCH;
                endcase
            end
            S_MEMRD:   state_next_s = S_MEMWB;
            S_RTYPEEX: state_next_s = S_RTYPEWB;
            S_ADDIEX:  state_next_s = S_ADDIWB;
            default:   state_next_s = S_FETCH;
        endcase
    end

    // Output table; reset and unreachable encodings leave every enable low.
    always_comb begin
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        illegal_op = 1'b0;
        aluop_s    = ALUOP_ADD;
        pcwrite_s  = 1'b0;
        branch_s   = 1'b0;
`ifdef CTRL_BNE_EN
        branchne_s = 1'b0;
`endif
        if (reset) begin
            aluop_s = ALUOP_ADD;
        end else begin
            case (state_r)
                S_FETCH: begin
                    irwrite   = 1'b1;
                    pcwrite_s = 1'b1;
                    alusrcb   = 2'b01;
                end
                S_DECODE: begin
                    alusrcb    = 2'b11;
                    illegal_op = ~is_supported_op(op);
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: iord = 1'b1;
                S_MEMWB: begin
                    memtoreg = 1'b1;
                    regwrite = 1'b1;
                end
                S_MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_RTYPEEX: begin
                    alusrca = 1'b1;
                    aluop_s = ALUOP_FUNCT;
                end
                S_RTYPEWB: begin
                    regdst   = 1'b1;
                    regwrite = 1'b1;
                end
                S_BEQEX: begin
                    alusrca  = 1'b1;
                    aluop_s  = ALUOP_SUB;
                    pcsrc    = 2'b01;
                    branch_s = 1'b1;
                end
`ifdef CTRL_BNE_EN
                S_BNEEX: begin
                    alusrca    = 1'b1;
                    aluop_s    = ALUOP_SUB;
                    pcsrc      = 2'b01;
                    branchne_s = 1'b1;
                end
`endif
                S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_JEX: begin
                    pcsrc     = 2'b10;
                    pcwrite_s = 1'b1;
                end
                default: aluop_s = ALUOP_ADD;
            endcase
        end
    end

`ifdef CTRL_BNE_EN
    assign pcen = pcwrite_s | (branch_s & zero) | (branchne_s & ~zero);
`else
    assign pcen = pcwrite_s | (branch_s & zero);
`endif

    alu_decoder u_alu_decoder (
        .aluop      (aluop_s),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

    multicycle_ctrl_checker u_checker (
        .clk      (clk),
        .reset    (reset),
        .memwrite (memwrite),
        .regwrite (regwrite),
        .irwrite  (irwrite)
    );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle table of inputs and
// hand-computed output words, plus hand-written corner sequences.
// Output word layout: {pcen, memwrite, irwrite, regwrite, iord, memtoreg,
// regdst, alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], illegal_op}.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal_op;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed expected output words per state
    localparam logic [15:0] E_RST    = 16'h0004;
    localparam logic [15:0] E_FETCH  = 16'hA044;
    localparam logic [15:0] E_DEC    = 16'h00C4;
    localparam logic [15:0] E_DECILL = 16'h00C5;
    localparam logic [15:0] E_MEMADR = 16'h0184;
    localparam logic [15:0] E_MEMRD  = 16'h0804;
    localparam logic [15:0] E_MEMWB  = 16'h1404;
    localparam logic [15:0] E_MEMWR  = 16'h4804;
    localparam logic [15:0] E_RTYPWB = 16'h1204;
    localparam logic [15:0] E_BRTAKE = 16'h811C;
    localparam logic [15:0] E_BRNOT  = 16'h011C;
    localparam logic [15:0] E_ADDIWB = 16'h1004;
    localparam logic [15:0] E_JEX    = 16'h8024;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [15:0] exp;
        int          tag;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] outs();
        return {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol, illegal_op};
    endfunction

    task automatic add(input logic r, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [15:0] e, input int t);
        vec_t v;
        v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One cycle: drive after the edge, sample on the falling edge
    task automatic apply(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        reset = v.rst; op = v.op; funct = v.funct; zero = v.zero;
        @(negedge clk);
        check($sformatf("vec%0d_tag%0d", idx, v.tag), outs(), v.exp);
    endtask

    logic [5:0]  fn_tab [6];
    logic [15:0] rx_tab [6];

    initial begin
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

        fn_tab[0] = 6'b101010; rx_tab[0] = 16'h010E;
        fn_tab[1] = 6'b100000; rx_tab[1] = 16'h0104;
        fn_tab[2] = 6'b100010; rx_tab[2] = 16'h010C;
        fn_tab[3] = 6'b100100; rx_tab[3] = 16'h0100;
        fn_tab[4] = 6'b100101; rx_tab[4] = 16'h0102;
        fn_tab[5] = 6'b111111; rx_tab[5] = 16'h0104;

        // reset
        add(1'b1, 6'd0, 6'd0, 1'b0, E_RST, 0);
        add(1'b1, 6'd0, 6'd0, 1'b0, E_RST, 0);
        // lw: 5 cycles
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_FETCH,  1);
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_DEC,    1);
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMADR, 1);
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMRD,  1);
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMWB,  1);
        // sw: 4 cycles
        add(1'b0, 6'b101011, 6'd0, 1'b0, E_FETCH,  2);
        add(1'b0, 6'b101011, 6'd0, 1'b0, E_DEC,    2);
        add(1'b0, 6'b101011, 6'd0, 1'b0, E_MEMADR, 2);
        add(1'b0, 6'b101011, 6'd0, 1'b0, E_MEMWR,  2);
        // R-type across all funct codes including an unknown one
        for (int i = 0; i < 6; i++) begin
            add(1'b0, 6'b000000, fn_tab[i], 1'b0, E_FETCH,   10 + i);
            add(1'b0, 6'b000000, fn_tab[i], 1'b0, E_DEC,     10 + i);
            add(1'b0, 6'b000000, fn_tab[i], 1'b0, rx_tab[i], 10 + i);
            add(1'b0, 6'b000000, fn_tab[i], 1'b0, E_RTYPWB,  10 + i);
        end
        // addi
        add(1'b0, 6'b001000, 6'd0, 1'b0, E_FETCH,  3);
        add(1'b0, 6'b001000, 6'd0, 1'b0, E_DEC,    3);
        add(1'b0, 6'b001000, 6'd0, 1'b0, E_MEMADR, 3);
        add(1'b0, 6'b001000, 6'd0, 1'b0, E_ADDIWB, 3);
        // beq taken / not taken
        add(1'b0, 6'b000100, 6'd0, 1'b1, E_FETCH,  4);
        add(1'b0, 6'b000100, 6'd0, 1'b1, E_DEC,    4);
        add(1'b0, 6'b000100, 6'd0, 1'b1, E_BRTAKE, 4);
        add(1'b0, 6'b000100, 6'd0, 1'b0, E_FETCH,  5);
        add(1'b0, 6'b000100, 6'd0, 1'b0, E_DEC,    5);
        add(1'b0, 6'b000100, 6'd0, 1'b0, E_BRNOT,  5);
        // j
        add(1'b0, 6'b000010, 6'd0, 1'b0, E_FETCH,  6);
        add(1'b0, 6'b000010, 6'd0, 1'b0, E_DEC,    6);
        add(1'b0, 6'b000010, 6'd0, 1'b0, E_JEX,    6);
        // unsupported opcode: pulse in DECODE, then straight back to FETCH
        add(1'b0, 6'b111111, 6'd0, 1'b0, E_FETCH,  7);
        add(1'b0, 6'b111111, 6'd0, 1'b0, E_DECILL, 7);
        add(1'b0, 6'b111111, 6'd0, 1'b0, E_FETCH,  7);
        add(1'b0, 6'b111111, 6'd0, 1'b0, E_DECILL, 7);
`ifdef CTRL_BNE_EN
        // bne not-equal branches, equal does not
        add(1'b0, 6'b000101, 6'd0, 1'b0, E_FETCH,  8);
        add(1'b0, 6'b000101, 6'd0, 1'b0, E_DEC,    8);
        add(1'b0, 6'b000101, 6'd0, 1'b0, E_BRTAKE, 8);
        add(1'b0, 6'b000101, 6'd0, 1'b1, E_FETCH,  9);
        add(1'b0, 6'b000101, 6'd0, 1'b1, E_DEC,    9);
        add(1'b0, 6'b000101, 6'd0, 1'b1, E_BRNOT,  9);
`else
        // bne is unsupported in this build
        add(1'b0, 6'b000101, 6'd0, 1'b0, E_FETCH,  8);
        add(1'b0, 6'b000101, 6'd0, 1'b0, E_DECILL, 8);
`endif
        // lw aborted by a 2-cycle reset during MEMRD, then a clean j
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_FETCH,  20);
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_DEC,    20);
        add(1'b0, 6'b100011, 6'd0, 1'b0, E_MEMADR, 20);
        add(1'b1, 6'b100011, 6'd0, 1'b0, E_RST,    20);
        add(1'b1, 6'b100011, 6'd0, 1'b0, E_RST,    20);
        add(1'b0, 6'b000010, 6'd0, 1'b0, E_FETCH,  21);
        add(1'b0, 6'b000010, 6'd0, 1'b0, E_DEC,    21);
        add(1'b0, 6'b000010, 6'd0, 1'b0, E_JEX,    21);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Hand sequence: pcen in BEQEX follows zero within the cycle
        @(posedge clk); #1; reset = 1'b0; op = 6'b000100; zero = 1'b0;
        @(negedge clk); check("beq_seq_fetch", outs(), E_FETCH);
        @(posedge clk); #1;
        @(negedge clk); check("beq_seq_decode", outs(), E_DEC);
        @(posedge clk); #1;
        check("beq_seq_zero0_pcen", {15'd0, pcen}, 16'd0);
        zero = 1'b1; #1;
        check("beq_seq_zero1_pcen", {15'd0, pcen}, 16'd1);
        check("beq_seq_pcsrc", {14'd0, pcsrc}, 16'd1);

        // Hand sequence: reset asserted in FETCH suppresses irwrite/pcen immediately
        @(posedge clk); #1; zero = 1'b0; op = 6'b100011;
        @(negedge clk); check("rst_seq_fetch", outs(), E_FETCH);
        reset = 1'b1; #1;
        check("rst_seq_forced", outs(), E_RST);
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk); check("rst_seq_refetch", outs(), E_FETCH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
